wb_ctrl: RTL

Writeback sequencer for the 16-bit core. It accepts one writeback request per instruction from execute and drives the writeback mux select, register-file write enable and write address. For memory and IO sources it holds the request until the external acknowledge arrives, or until a bounded timeout expires. It sits between execute, the data-memory/IO ports and the writeback mux/register file.

---
 rtl/eye_pkg.sv | 31 +++
 rtl/wb_timer.sv | 27 ++
 rtl/wb_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/eye_pkg.sv
// Shared types for the writeback path: mux select codes, sequencer states
// and the source-code canonicalisation helper.
package eye_pkg;

  typedef enum logic [2:0] {
    WB_ALU = 3'b000,
    WB_IMM = 3'b001,
    WB_MEM = 3'b010,
    WB_IO  = 3'b011,
    WB_PC  = 3'b100,
    WB_SP  = 3'b101
  } wb_sel_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_MEM,
    S_WAIT_IO,
    S_WRITE
  } wb_state_e;

  localparam int TIMER_W = 8;

  // Reserved source codes fall back to the ALU path.
  function automatic wb_sel_e canon_src(input logic [2:0] src);
    case (src)
      3'b110, 3'b111: return WB_ALU;
      default:        return wb_sel_e'(src);
    endcase
  endfunction

endpackage

// File: rtl/wb_timer.sv
// Bounded wait counter: cleared while idle, counts while enabled and flags
// the last permitted cycle (count == TIMEOUT-1).
module wb_timer
  import eye_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign hit = enable && (count == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_ctrl.sv
// Writeback sequencer: accepts one request per instruction, steers the
// writeback mux and register-file write, waiting on MEM/IO acks with timeout.
module wb_ctrl
  import eye_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int REG_AW  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_src,
  input  logic [REG_AW-1:0] req_rd,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic              io_req,
  input  logic              io_ack,
  output logic [2:0]        wb_sel,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic              busy,
  output logic              err_timeout
);

  wb_state_e state;
  logic      accept;
  logic      in_wait;
  logic      tmo_hit;
  wb_sel_e   src_c;

  assign req_ready = (state == S_IDLE) || (state == S_WRITE);
  assign busy      = (state != S_IDLE);
  assign accept    = req_valid && req_ready;
  assign in_wait   = (state == S_WAIT_MEM) || (state == S_WAIT_IO);
  assign src_c     = canon_src(req_src);

  wb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!in_wait),
    .enable (in_wait),
    .hit    (tmo_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wb_sel      <= 3'b000;
      rf_waddr    <= '0;
      rf_we       <= 1'b0;
      mem_req     <= 1'b0;
      io_req      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      rf_we       <= 1'b0;
      mem_req     <= 1'b0;
      io_req      <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        S_IDLE, S_WRITE: begin
          if (accept) begin
            rf_waddr <= req_rd;
            wb_sel   <= src_c;
            case (src_c)
              WB_MEM: begin
                state   <= S_WAIT_MEM;
                mem_req <= 1'b1;
              end
              WB_IO: begin
                state  <= S_WAIT_IO;
                io_req <= 1'b1;
              end
              default: begin
                state <= S_WRITE;
                rf_we <= 1'b1;
              end
            endcase
          end else begin
            state <= S_IDLE;
          end
        end
        // Ack beats a simultaneous timeout; cross acks are never looked at.
        S_WAIT_MEM: begin
          if (mem_ack) begin
            state <= S_WRITE;
            rf_we <= 1'b1;
          end else if (tmo_hit) begin
            state       <= S_IDLE;
            err_timeout <= 1'b1;
          end else begin
            mem_req <= 1'b1;
          end
        end
        S_WAIT_IO: begin
          if (io_ack) begin
            state <= S_WRITE;
            rf_we <= 1'b1;
          end else if (tmo_hit) begin
            state       <= S_IDLE;
            err_timeout <= 1'b1;
          end else begin
            io_req <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
